// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: timestamps register writebacks into a FWFT FIFO drained via valid/ready,
// with overflow accounting, drain-on-done and an idle watchdog.
module wb_trace_buffer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                       CK,
  input  logic                       RESET,
  input  logic [ADDR_W-1:0]          WB_ADDR,
  input  logic [DATA_W-1:0]          WB_DATA,
  input  logic                       WB_VALID,
  input  logic                       CPU_DONE,
  input  logic                       RD_READY,
  output logic                       RD_VALID,
  output logic [TS_W-1:0]            RD_TS,
  output logic [ADDR_W-1:0]          RD_ADDR,
  output logic [DATA_W-1:0]          RD_DATA,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       OVERFLOW,
  output logic [TS_W-1:0]            DROP_CNT,
  output logic                       TIMED_OUT,
  output logic                       FINISHED
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = TS_W + ADDR_W + DATA_W;
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t              state, state_next;
  logic [TS_W-1:0]     count;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    push_ent, head_next;
  logic [LVL_W-1:0]    level_next;
  logic                push, pop, full, wr_en, drop, timeout_hit, set_timed_out;

  // FIFO datapath: push/pop qualification and next head entry
  always_comb begin
    push        = (state == S_RUN) && WB_VALID;
    pop         = RD_VALID && RD_READY;
    full        = (LEVEL == LVL_W'(DEPTH));
    wr_en       = push && (!full || pop);
    drop        = push && full && !pop;
    level_next  = LEVEL + LVL_W'(wr_en) - LVL_W'(pop);
    rd_ptr_next = rd_ptr + PTR_W'(pop);
    push_ent    = {count, WB_ADDR, WB_DATA};
    timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_W'(TIMEOUT - 1)) && !WB_VALID;
    head_next   = '0;
    // Head is registered; bypass the incoming entry when it lands in the head slot
    if (level_next != '0) begin
      if (wr_en && (wr_ptr == rd_ptr_next)) head_next = push_ent;
      else                                  head_next = mem[rd_ptr_next];
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state;
    set_timed_out = 1'b0;
    case (state)
      S_IDLE:  state_next = S_RUN;
      S_RUN: begin
        if (CPU_DONE) begin
          state_next = S_DRAIN;
        end else if (timeout_hit) begin
          state_next    = S_DRAIN;
          set_timed_out = 1'b1;
        end
      end
      S_DRAIN: if ((LEVEL == '0) && !pop) state_next = S_HALT;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge CK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      count     <= '0;
      idle_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      RD_VALID  <= 1'b0;
      RD_TS     <= '0;
      RD_ADDR   <= '0;
      RD_DATA   <= '0;
      LEVEL     <= '0;
      OVERFLOW  <= 1'b0;
      DROP_CNT  <= '0;
      TIMED_OUT <= 1'b0;
      FINISHED  <= 1'b0;
    end else begin
      state    <= state_next;
      if (state != S_HALT) count <= count + TS_W'(1);
      idle_cnt <= ((state == S_RUN) && !WB_VALID) ? idle_cnt + IDLE_W'(1) : '0;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_next;
      LEVEL    <= level_next;
      RD_VALID <= (level_next != '0);
      {RD_TS, RD_ADDR, RD_DATA} <= head_next;
      if (drop) begin
        OVERFLOW <= 1'b1;
        if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + TS_W'(1);
      end
      if (set_timed_out) TIMED_OUT <= 1'b1;
      FINISHED <= (state_next == S_HALT);
    end
  end

  // Entry storage; not reset, contents are qualified by LEVEL
  always_ff @(posedge CK) begin
    if (RESET && wr_en) mem[wr_ptr] <= push_ent;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: main instance at default parameters,
// second instance with TIMEOUT=8 for the watchdog.
module tb_wb_trace_buffer;

  logic        CK = 1'b0;
  always #5 CK = ~CK;

  logic        reset, wb_valid, cpu_done, rd_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rd_valid, overflow, timed_out, finished;
  logic [15:0] rd_ts, drop_cnt;
  logic [4:0]  rd_addr, level;
  logic [31:0] rd_data;

  logic        w_reset = 1'b0;
  logic        w_done  = 1'b0;
  logic        w_rd_valid, w_overflow, w_timed_out, w_finished;
  logic [15:0] w_rd_ts, w_drop_cnt;
  logic [4:0]  w_rd_addr, w_level;
  logic [31:0] w_rd_data;

  int checks   = 0;
  int failures = 0;

  wb_trace_buffer u_dut (
    .CK(CK), .RESET(reset), .WB_ADDR(wb_addr), .WB_DATA(wb_data), .WB_VALID(wb_valid),
    .CPU_DONE(cpu_done), .RD_READY(rd_ready), .RD_VALID(rd_valid), .RD_TS(rd_ts),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data), .LEVEL(level), .OVERFLOW(overflow),
    .DROP_CNT(drop_cnt), .TIMED_OUT(timed_out), .FINISHED(finished)
  );

  wb_trace_buffer #(.TIMEOUT(8)) u_wd (
    .CK(CK), .RESET(w_reset), .WB_ADDR(5'd0), .WB_DATA(32'd0), .WB_VALID(1'b0),
    .CPU_DONE(w_done), .RD_READY(1'b1), .RD_VALID(w_rd_valid), .RD_TS(w_rd_ts),
    .RD_ADDR(w_rd_addr), .RD_DATA(w_rd_data), .LEVEL(w_level), .OVERFLOW(w_overflow),
    .DROP_CNT(w_drop_cnt), .TIMED_OUT(w_timed_out), .FINISHED(w_finished)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the start of cycle 0 (IDLE, COUNT=0)
  task automatic do_reset();
    reset = 1'b0; wb_valid = 1'b0; cpu_done = 1'b0; rd_ready = 1'b0;
    wb_addr = 5'd0; wb_data = 32'd0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    // Test 1: reset values, then three writebacks drained as they arrive
    do_reset();
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ts", 64'(rd_ts), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_tmo", 64'(timed_out), 64'(0));
    chk("rst_fin", 64'(finished), 64'(0));
    step(2);
    wb_valid = 1'b1; wb_addr = 5'h08; wb_data = 32'h0000000A; rd_ready = 1'b1;
    step();
    chk("t1_valid", 64'(rd_valid), 64'(1));
    chk("t1_ts0", 64'(rd_ts), 64'(2));
    chk("t1_addr", 64'(rd_addr), 64'(8));
    chk("t1_data", 64'(rd_data), 64'(32'hA));
    chk("t1_lvl0", 64'(level), 64'(1));
    step();
    chk("t1_ts1", 64'(rd_ts), 64'(3));
    chk("t1_lvl1", 64'(level), 64'(1));
    step();
    chk("t1_ts2", 64'(rd_ts), 64'(4));
    chk("t1_lvl2", 64'(level), 64'(1));
    wb_valid = 1'b0;
    step();
    chk("t1_empty", 64'(rd_valid), 64'(0));
    chk("t1_lvl3", 64'(level), 64'(0));
    chk("t1_ts_empty", 64'(rd_ts), 64'(0));

    // Test 2: 20 writebacks into a stalled consumer
    do_reset();
    step(2);
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'(i);
      step();
    end
    chk("t2_level", 64'(level), 64'(16));
    chk("t2_ovf", 64'(overflow), 64'(1));
    chk("t2_drop", 64'(drop_cnt), 64'(4));
    chk("t2_head_ts", 64'(rd_ts), 64'(2));
    chk("t2_head_data", 64'(rd_data), 64'(0));

    // Test 3: push and pop together while full (cycle 22)
    wb_addr = 5'd31; wb_data = 32'h00000ABC; rd_ready = 1'b1;
    step();
    chk("t3_level", 64'(level), 64'(16));
    chk("t3_drop", 64'(drop_cnt), 64'(4));
    chk("t3_head_ts", 64'(rd_ts), 64'(3));
    wb_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("t2_drain_data%0d", k), 64'(rd_data), 64'(k));
      chk($sformatf("t2_drain_ts%0d", k), 64'(rd_ts), 64'(k + 2));
      step();
    end
    chk("t3_tail_data", 64'(rd_data), 64'(32'hABC));
    chk("t3_tail_ts", 64'(rd_ts), 64'(22));
    chk("t3_tail_addr", 64'(rd_addr), 64'(31));
    step();
    chk("t3_empty", 64'(rd_valid), 64'(0));
    chk("t3_lvl", 64'(level), 64'(0));

    // Test 4: CPU_DONE with a final writeback, drain to HALT
    do_reset();
    chk("t4_ovf_clr", 64'(overflow), 64'(0));
    chk("t4_drop_clr", 64'(drop_cnt), 64'(0));
    step(2);
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i + 1); wb_data = 32'h100 + 32'(i);
      step();
    end
    wb_addr = 5'd4; wb_data = 32'h103; cpu_done = 1'b1;
    step();
    chk("t4_level", 64'(level), 64'(4));
    chk("t4_fin0", 64'(finished), 64'(0));
    cpu_done = 1'b0; wb_data = 32'hDEAD; rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), 64'(rd_data), 64'(32'h100 + i));
      chk($sformatf("t4_ts%0d", i), 64'(rd_ts), 64'(2 + i));
      step();
    end
    chk("t4_drained", 64'(level), 64'(0));
    chk("t4_fin1", 64'(finished), 64'(0));
    step();
    chk("t4_fin2", 64'(finished), 64'(1));
    chk("t4_tmo", 64'(timed_out), 64'(0));
    chk("t4_count", 64'(u_dut.count), 64'(11));
    step(3);
    chk("t4_count_frozen", 64'(u_dut.count), 64'(11));
    chk("t4_no_capture", 64'(level), 64'(0));
    chk("t4_fin3", 64'(finished), 64'(1));
    wb_valid = 1'b0;

    // Test 6: reset mid-run with 5 buffered entries
    do_reset();
    chk("t6_fin_clr", 64'(finished), 64'(0));
    step(2);
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'h200 + 32'(i);
      step();
    end
    wb_valid = 1'b0;
    chk("t6_level5", 64'(level), 64'(5));
    reset = 1'b0;
    step();
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_valid", 64'(rd_valid), 64'(0));
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_fin", 64'(finished), 64'(0));
    chk("t6_count", 64'(u_dut.count), 64'(0));
    reset = 1'b1;
    step(2);
    wb_valid = 1'b1; wb_data = 32'h55;
    step();
    chk("t6_restart_ts", 64'(rd_ts), 64'(2));
    chk("t6_restart_data", 64'(rd_data), 64'(32'h55));
    wb_valid = 1'b0;

    // Test 5: watchdog with TIMEOUT=8 and no writebacks
    w_reset = 1'b0;
    step(2);
    w_reset = 1'b1;
    step(8);
    chk("t5_idle7", 64'(u_wd.idle_cnt), 64'(7));
    chk("t5_tmo0", 64'(w_timed_out), 64'(0));
    step();
    chk("t5_tmo1", 64'(w_timed_out), 64'(1));
    chk("t5_fin0", 64'(w_finished), 64'(0));
    step();
    chk("t5_fin1", 64'(w_finished), 64'(1));
    chk("t5_tmo_sticky", 64'(w_timed_out), 64'(1));

    // CPU_DONE in the watchdog cycle wins: no timeout flagged
    w_reset = 1'b0;
    step(2);
    w_reset = 1'b1;
    chk("t5b_tmo_clr", 64'(w_timed_out), 64'(0));
    step(8);
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    chk("t5b_tmo", 64'(w_timed_out), 64'(0));
    step();
    chk("t5b_fin", 64'(w_finished), 64'(1));
    chk("t5b_tmo_end", 64'(w_timed_out), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
